// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
// Merges two requesters onto the single write port of the cache's simple
// dual-port RAM. Requester A carries single-beat CPU store hits. Requester B
// carries multi-beat line refills. The selected beat is registered onto the
// RAM write signals, so it appears one cycle after it is accepted.
//
// Optional feature, enabled by defining RAM_INIT_CLEAR_EN:
//   After reset, the whole array is swept to zero before any requester is
//   served. initDone rises on the same cycle as the final clear write.
//   Without the macro there is no sweep, and initDone is constant 1.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   aValid/aReady             requester A handshake
//   aAddress/aData/aByteEnable  requester A beat
//   bValid/bReady/bLast       requester B handshake and end-of-burst marker
//   bAddress/bData/bByteEnable  requester B beat
//   writeAddress/writeData/writeEnable/writeByteEnable  registered RAM write port
//   initDone                  array ready; requesters are served only while high
module ram_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BE = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aValid,
  output logic             aReady,
  input  logic [AW-1:0]    aAddress,
  input  logic [WIDTH-1:0] aData,
  input  logic [BE-1:0]    aByteEnable,
  input  logic             bValid,
  output logic             bReady,
  input  logic [AW-1:0]    bAddress,
  input  logic [WIDTH-1:0] bData,
  input  logic [BE-1:0]    bByteEnable,
  input  logic             bLast,
  output logic [AW-1:0]    writeAddress,
  output logic [WIDTH-1:0] writeData,
  output logic             writeEnable,
  output logic [BE-1:0]    writeByteEnable,
  output logic             initDone
);

  typedef enum logic {PRI_A, PRI_B} pri_t;

  pri_t pri;
  logic lock;
  logic run;
  logic a_acc;
  logic b_acc;

`ifdef RAM_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] clr_addr;

  assign run = (state == RUN) && !rst;
`else
  assign run      = !rst;
  assign initDone = 1'b1;
`endif

  // While a burst is locked, B owns the port even across bValid gaps,
  // so A is held off until the last beat is accepted.
  always_comb begin
    aReady = 1'b0;
    bReady = 1'b0;
    if (run) begin
      if (lock) begin
        bReady = 1'b1;
      end else begin
        aReady = aValid && (!bValid || pri == PRI_A);
        bReady = bValid && (!aValid || pri == PRI_B);
      end
    end
  end

  assign a_acc = aValid && aReady;
  assign b_acc = bValid && bReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      pri             <= PRI_A;
      lock            <= 1'b0;
      writeEnable     <= 1'b0;
      writeAddress    <= '0;
      writeData       <= '0;
      writeByteEnable <= '0;
`ifdef RAM_INIT_CLEAR_EN
      state           <= INIT;
      clr_addr        <= '0;
      initDone        <= 1'b0;
`endif
    end else begin
      writeEnable <= 1'b0;
      if (a_acc) begin
        writeEnable     <= 1'b1;
        writeAddress    <= aAddress;
        writeData       <= aData;
        writeByteEnable <= aByteEnable;
      end else if (b_acc) begin
        writeEnable     <= 1'b1;
        writeAddress    <= bAddress;
        writeData       <= bData;
        writeByteEnable <= bByteEnable;
      end
`ifdef RAM_INIT_CLEAR_EN
      else if (state == INIT) begin
        writeEnable     <= 1'b1;
        writeAddress    <= clr_addr;
        writeData       <= '0;
        writeByteEnable <= '1;
        // Stop exactly at DEPTH-1 so a non-power-of-2 array never wraps
        // into unused addresses.
        if (clr_addr == LAST_ADDR) begin
          state    <= RUN;
          initDone <= 1'b1;
        end else begin
          clr_addr <= clr_addr + AW'(1);
        end
      end
`endif

      // The end of a burst always hands priority back to A; otherwise a
      // contested cycle flips priority to the side that lost.
      if (b_acc && bLast) begin
        pri <= PRI_A;
      end else if (run && !lock && aValid && bValid) begin
        pri <= (pri == PRI_A) ? PRI_B : PRI_A;
      end

      if (b_acc) begin
        lock <= !bLast;
      end
    end
  end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Self-checking bench for ram_write_arbiter (DEPTH=16, WIDTH=32).
// A reference model predicts grants and the expected RAM writes; predicted
// writes are queued and compared when the DUT presents them one cycle later.
module tb_ram_write_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BE    = 4;

`ifdef RAM_INIT_CLEAR_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             aValid;
  logic             aReady;
  logic [AW-1:0]    aAddress;
  logic [WIDTH-1:0] aData;
  logic [BE-1:0]    aByteEnable;
  logic             bValid;
  logic             bReady;
  logic [AW-1:0]    bAddress;
  logic [WIDTH-1:0] bData;
  logic [BE-1:0]    bByteEnable;
  logic             bLast;
  logic [AW-1:0]    writeAddress;
  logic [WIDTH-1:0] writeData;
  logic             writeEnable;
  logic [BE-1:0]    writeByteEnable;
  logic             initDone;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state
  logic [AW+WIDTH+BE-1:0] expQ[$];
  logic [AW+WIDTH+BE-1:0] mLast;
  logic                   mPri;
  logic                   mLock;
  logic                   mRun;
  logic                   mDone;
  logic [AW-1:0]          mClr;

  ram_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .aValid(aValid),
    .aReady(aReady),
    .aAddress(aAddress),
    .aData(aData),
    .aByteEnable(aByteEnable),
    .bValid(bValid),
    .bReady(bReady),
    .bAddress(bAddress),
    .bData(bData),
    .bByteEnable(bByteEnable),
    .bLast(bLast),
    .writeAddress(writeAddress),
    .writeData(writeData),
    .writeEnable(writeEnable),
    .writeByteEnable(writeByteEnable),
    .initDone(initDone)
  );

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check the registered outputs from the previous edge,
  // drive this cycle's inputs, check the readies against the model, then
  // advance the model as if the next rising edge had happened.
  task automatic applyStimulus(
    input  logic r,
    input  logic av, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad,
    input  logic [BE-1:0] ab,
    input  logic bv, input logic [AW-1:0] ba, input logic [WIDTH-1:0] bd,
    input  logic [BE-1:0] bb, input logic bl,
    output logic accA, output logic accB);
    logic expWe, expA, expB, run;
    @(negedge clk);
    expWe = (expQ.size() > 0);
    checkOutput("writeEnable", 64'(writeEnable), 64'(expWe));
    if (expWe) mLast = expQ.pop_front();
    checkOutput("writeBus", 64'({writeAddress, writeData, writeByteEnable}), 64'(mLast));
    checkOutput("initDone", 64'(initDone), 64'(mDone));

    rst = r; aValid = av; aAddress = aa; aData = ad; aByteEnable = ab;
    bValid = bv; bAddress = ba; bData = bd; bByteEnable = bb; bLast = bl;
    #1;
    run  = !r && mRun;
    expA = 1'b0;
    expB = 1'b0;
    if (run) begin
      if (mLock) expB = 1'b1;
      else begin
        expA = av && (!bv || mPri == 1'b0);
        expB = bv && (!av || mPri == 1'b1);
      end
    end
    if (av) checkOutput("aReady", 64'(aReady), 64'(expA));
    if (bv) checkOutput("bReady", 64'(bReady), 64'(expB));
    accA = av && expA;
    accB = bv && expB;

    if (r) begin
      mPri  = 1'b0;
      mLock = 1'b0;
      mRun  = !INIT_EN;
      mDone = !INIT_EN;
      mClr  = '0;
      mLast = '0;
      expQ.delete();
    end else begin
      if (accA) expQ.push_back({aa, ad, ab});
      else if (accB) expQ.push_back({ba, bd, bb});
      else if (!mRun) begin
        expQ.push_back({mClr, {WIDTH{1'b0}}, {BE{1'b1}}});
        if (mClr == AW'(DEPTH - 1)) begin
          mRun  = 1'b1;
          mDone = 1'b1;
        end else mClr = mClr + 1'b1;
      end
      if (accB && bl) mPri = 1'b0;
      else if (run && !mLock && av && bv) mPri = ~mPri;
      if (accB) mLock = !bl;
    end
  endtask

  task automatic idle(input logic r);
    logic accA, accB;
    applyStimulus(r, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, accA, accB);
  endtask

  // Main sequence: reset, sweep with a mid-sweep reset, single store,
  // contested grants, locked burst with gaps, and a mid-burst reset.
  initial begin
    logic accA, accB, done;
    int   bIdx, gapLeft;

    rst = 1'b1; aValid = 1'b0; aAddress = '0; aData = '0; aByteEnable = '0;
    bValid = 1'b0; bAddress = '0; bData = '0; bByteEnable = '0; bLast = 1'b0;
    mPri = 1'b0; mLock = 1'b0; mRun = !INIT_EN; mDone = !INIT_EN; mClr = '0;
    mLast = '0;
    repeat (2) @(posedge clk);

    idle(1'b1);
    idle(1'b1);

    // Sweep addresses 0..7, then reset on top of it
    for (int i = 0; i < 8; i++) idle(1'b0);
    idle(1'b1);

    // Single A store held until accepted (immediately when no sweep)
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      applyStimulus(1'b0, 1'b1, 4'h3, 32'hDEADBEEF, 4'b0101,
                    1'b0, '0, '0, '0, 1'b0, accA, accB);
      done = accA;
    end
    if (!done) checkOutput("timeoutStore", 64'(0), 64'(1));
    idle(1'b0);
    idle(1'b0);

    // Both requesters valid for 4 cycles: A,B,A,B
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 4'h1, 32'hA1A1A1A1, 4'b1111,
                    1'b1, 4'h2, 32'hB2B2B2B2, 4'b0011, 1'b1, accA, accB);
    idle(1'b0);

    // Four-beat B burst, A valid throughout, bValid gap after beat 2
    bIdx = 0; gapLeft = 0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (gapLeft > 0) begin
        gapLeft--;
        applyStimulus(1'b0, 1'b1, 4'h5, 32'hAAAA5555, 4'b1100,
                      1'b0, '0, '0, '0, 1'b0, accA, accB);
      end else begin
        applyStimulus(1'b0, 1'b1, 4'h5, 32'hAAAA5555, 4'b1100,
                      (bIdx < 4), AW'(8 + bIdx), 32'hB0 + 32'(bIdx), 4'b1111,
                      (bIdx == 3), accA, accB);
        if (accB) begin
          bIdx++;
          if (bIdx == 2) gapLeft = 2;
        end
      end
      done = accA && (bIdx == 4);
    end
    if (!done) checkOutput("timeoutBurst", 64'(0), 64'(1));
    idle(1'b0);

    // Burst abandoned by reset after beat 2; A must win afterwards
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b0, 1'b0, '0, '0, '0,
                    1'b1, AW'(12 + i), 32'hC0 + 32'(i), 4'b1010, 1'b0, accA, accB);
    idle(1'b1);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      applyStimulus(1'b0, 1'b1, 4'h6, 32'h66666666, 4'b0110,
                    1'b1, 4'hE, 32'hEEEEEEEE, 4'b1001, 1'b1, accA, accB);
      done = accA;
    end
    if (!done) checkOutput("timeoutPostReset", 64'(0), 64'(1));
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("queueDrained", 64'(expQ.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/ram_write_arbiter.md
# ram_write_arbiter

Sequencer and arbiter for the write port of the cache's simple dual-port RAM. It merges two write requesters onto the RAM's single write port: A (CPU store hits, single beat) and B (line refill, multi-beat bursts). It registers the selected beat onto the RAM write signals and, optionally, sweeps the whole array to zero after reset. It sits between the cache control FSMs and the dual-port RAM instance; the RAM read port is untouched.

## Interface
Parameters:
- WIDTH, 32, data width; byte-enable width BE = (WIDTH+7)/8
- DEPTH, 1024, RAM words; address width AW = ceil(log2(DEPTH)), derived locally, not overridable

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- aValid  in  1  requester A beat valid
- aReady  out  1  requester A beat accepted this cycle (when aValid)
- aAddress  in  AW  A word address
- aData  in  WIDTH  A write data
- aByteEnable  in  BE  A byte enables
- bValid  in  1  requester B beat valid
- bReady  out  1  requester B beat accepted this cycle (when bValid)
- bAddress  in  AW  B word address
- bData  in  WIDTH  B write data
- bByteEnable  in  BE  B byte enables
- bLast  in  1  final beat of B burst
- writeAddress  out  AW  to RAM write address
- writeData  out  WIDTH  to RAM write data
- writeEnable  out  1  to RAM write enable
- writeByteEnable  out  BE  to RAM byte enables
- initDone  out  1  array ready; requesters served only when high

## Operation
- States: INIT (clear sweep) and RUN. Reset enters INIT (macro defined) or RUN (macro undefined).
- INIT: counter clrAddr runs 0..DEPTH-1, one write per cycle, data 0, all byte enables 1. After issuing DEPTH-1, go to RUN and set initDone. aReady=bReady=0 throughout INIT.
- RUN: aReady and bReady are combinational from valids, lock, and priority bit pri. At most one is high per cycle.
- Unlocked, one valid: that side is granted.
- Unlocked, both valid: the side named by pri is granted. pri then points at the other side. pri resets to A.
- Lock: a B beat accepted with bLast=0 sets lock. While locked, only B can be granted, aReady=0 even if bValid is low (gaps inside a burst allowed). An accepted B beat with bLast=1 clears lock and sets pri=A.
- A single-beat B (bLast=1 on first beat) never locks.
- Accepted beat: address, data and byte enables registered to write* outputs with writeEnable=1 for exactly one cycle. With no acceptance, writeEnable=0 and the other write* outputs hold their previous values.
- Invalid requesters' aReady/bReady may be computed but carry no meaning when the corresponding valid is low.

## Timing
- Reset values: writeEnable=0, writeAddress=0, writeData=0, writeByteEnable=0, initDone=0 (macro defined), aReady=bReady=0 during rst.
- Write latency: beat accepted at edge N appears on write* in cycle N+1. Throughput is 1 beat/cycle.
- Sweep: first clear write on outputs the cycle after the first edge with rst low. Clear writes occupy DEPTH consecutive cycles for addresses 0..DEPTH-1 in order. initDone rises with the final clear write on the outputs. The first requester acceptance is possible on that same cycle.
- Non-power-of-2 DEPTH: sweep stops at DEPTH-1, no wrap to unused addresses.
- rst mid-sweep or mid-burst: restart at INIT/clrAddr=0 (or RUN), lock=0, pri=A, outputs to reset values. Any burst in flight is abandoned; the requester must restart it.
- Requesters must hold address/data/enables stable while valid and not ready.

## Configuration
- RAM_INIT_CLEAR_EN defined: INIT sweep present as above; initDone resets to 0.
- RAM_INIT_CLEAR_EN undefined: no sweep counter, reset goes straight to RUN, initDone constant 1 (including during rst). Requesters may be accepted on the first cycle after rst falls.

## Test plan
- DEPTH=16, macro on, release rst: writeEnable high 16 cycles, addresses 0..15, data 0, BE all ones; initDone rises on address-15 cycle; aReady=0 during sweep.
- RUN, aValid and bValid(bLast=1) held high 4 cycles: grants A,B,A,B. Write outputs follow one cycle later with matching address/data.
- B burst of 4 beats (bLast on beat 4), aValid high throughout, bValid dropped for 2 cycles after beat 2: aReady stays 0 until beat 4 accepted, then A granted next cycle.
- aValid only, aAddress=0x3, aData=0xDEADBEEF, aByteEnable=4'b0101: next cycle writeEnable=1, writeAddress=3, writeData=0xDEADBEEF, writeByteEnable=4'b0101, then writeEnable=0.
- Assert rst at sweep address 7, and again mid-burst after beat 2: sweep restarts at 0; lock cleared, pri=A, A accepted once out of reset/INIT.
- Macro off: initDone=1 during and after rst; aValid in first cycle after rst falls is accepted immediately.
